// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile controller and its buffers.
package systolic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } sys_ctrl_state_e;

  // Bit offset of lane number `lane` in a bus of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Lane number holding C(r,c) in the flattened result bus.
  function automatic int c_lane(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Controller <-> systolic_array link: operand beats out, accumulated results back.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic                         arr_acc_clr;
  logic                         arr_valid_in;
  logic [ROWS*DATA_W-1:0]       arr_a_bus;
  logic [COLS*DATA_W-1:0]       arr_b_bus;
  logic [ROWS*COLS*ACC_W-1:0]   arr_c_bus;
  logic [ROWS*COLS-1:0]         arr_c_valid;

  modport master (
    output arr_acc_clr,
    output arr_valid_in,
    output arr_a_bus,
    output arr_b_bus,
    input  arr_c_bus,
    input  arr_c_valid
  );

  modport slave (
    input  arr_acc_clr,
    input  arr_valid_in,
    input  arr_a_bus,
    input  arr_b_bus,
    output arr_c_bus,
    output arr_c_valid
  );

endinterface

// File: rtl/sys_operand_buf.sv
// Operand store: one synchronous write port, one combinational read port.
module sys_operand_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer: buffers A/B operands, streams them into the systolic array,
// waits for the drain and captures the C results.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int K_MAX     = 16,
  parameter int FLUSH_MAX = 64,
  localparam int KW       = $clog2(K_MAX + 1),
  localparam int AW       = $clog2(K_MAX),
  localparam int FW       = $clog2(FLUSH_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [KW-1:0]              k_len,
  input  logic                       a_wr_en,
  input  logic [AW-1:0]              a_wr_addr,
  input  logic [ROWS*DATA_W-1:0]     a_wr_data,
  input  logic                       b_wr_en,
  input  logic [AW-1:0]              b_wr_addr,
  input  logic [COLS*DATA_W-1:0]     b_wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ROWS*COLS*ACC_W-1:0] c_out,
  systolic_ctrl_if.master            arr_if
);

  localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_MAX - 1);

  sys_ctrl_state_e state_reg, state_next;
  logic [KW-1:0]   k_len_reg;
  logic [KW-1:0]   k_reg, k_next;
  logic [FW-1:0]   flush_reg, flush_next;
  logic            err_reg, err_next;
  logic            capture;

  logic                   a_we, b_we;
  logic [AW-1:0]          rd_addr;
  logic [ROWS*DATA_W-1:0] a_rd;
  logic [COLS*DATA_W-1:0] b_rd;

  // Buffers only accept writes while idle so a run sees a frozen snapshot.
  assign a_we    = a_wr_en && (state_reg == IDLE);
  assign b_we    = b_wr_en && (state_reg == IDLE);
  assign rd_addr = k_reg[AW-1:0];

  sys_operand_buf #(
    .WIDTH (ROWS*DATA_W),
    .DEPTH (K_MAX)
  ) u_abuf (
    .clk     (clk),
    .wr_en   (a_we),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .rd_addr (rd_addr),
    .rd_data (a_rd)
  );

  sys_operand_buf #(
    .WIDTH (COLS*DATA_W),
    .DEPTH (K_MAX)
  ) u_bbuf (
    .clk     (clk),
    .wr_en   (b_we),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .rd_addr (rd_addr),
    .rd_data (b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_len_reg <= '0;
      k_reg     <= '0;
      flush_reg <= '0;
      err_reg   <= 1'b0;
      c_out     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      flush_reg <= flush_next;
      err_reg   <= err_next;
      if (state_reg == IDLE && start) begin
        k_len_reg <= k_len;
      end
      if (capture) begin
        c_out <= arr_if.arr_c_bus;
      end
    end
  end

  always_comb begin
    state_next          = state_reg;
    k_next              = k_reg;
    flush_next          = flush_reg;
    err_next            = err_reg;
    capture             = 1'b0;
    busy                = (state_reg != IDLE);
    done                = 1'b0;
    err                 = 1'b0;
    arr_if.arr_acc_clr  = 1'b0;
    arr_if.arr_valid_in = 1'b0;
    arr_if.arr_a_bus    = '0;
    arr_if.arr_b_bus    = '0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          err_next   = 1'b0;
        end
      end
      CLEAR: begin
        arr_if.arr_acc_clr = 1'b1;
        k_next             = '0;
        if (k_len_reg == '0 || k_len_reg > K_MAX_V) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        arr_if.arr_valid_in = 1'b1;
        arr_if.arr_a_bus    = a_rd;
        arr_if.arr_b_bus    = b_rd;
        k_next              = k_reg + KW'(1);
        if (k_reg == k_len_reg - KW'(1)) begin
          state_next = FLUSH;
          flush_next = '0;
        end
      end
      FLUSH: begin
        flush_next = flush_reg + FW'(1);
        // A result arriving on the final allowed cycle still wins over the timeout.
        if (&arr_if.arr_c_valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (flush_reg == FLUSH_LAST) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        err        = err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioural array model plus a scoreboard of expected runs.
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 32;
  localparam int ROWS      = 2;
  localparam int COLS      = 2;
  localparam int K_MAX     = 16;
  localparam int FLUSH_MAX = 64;
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int AW        = $clog2(K_MAX);
  localparam int CW        = ROWS * COLS * ACC_W;
  localparam int DRAIN_CYC = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [KW-1:0]          k_len = '0;
  logic                   a_wr_en = 1'b0;
  logic [AW-1:0]          a_wr_addr = '0;
  logic [ROWS*DATA_W-1:0] a_wr_data = '0;
  logic                   b_wr_en = 1'b0;
  logic [AW-1:0]          b_wr_addr = '0;
  logic [COLS*DATA_W-1:0] b_wr_data = '0;
  logic                   start = 1'b0;
  logic                   busy, done, err;
  logic [CW-1:0]          c_out;

  systolic_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) arr_if ();

  systolic_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS),
    .K_MAX(K_MAX), .FLUSH_MAX(FLUSH_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .k_len(k_len),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .start(start), .busy(busy), .done(done), .err(err), .c_out(c_out),
    .arr_if(arr_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural systolic array ----------------
  logic signed [ACC_W-1:0] acc [ROWS][COLS];
  bit seen = 1'b0;
  int drain = 0;
  bit kill = 1'b0;

  function automatic logic signed [ACC_W-1:0] sx(input logic [DATA_W-1:0] v);
    return ACC_W'($signed(v));
  endfunction

  always @(posedge clk) begin
    if (arr_if.arr_acc_clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
      seen  <= 1'b0;
      drain <= 0;
    end else if (arr_if.arr_valid_in) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= acc[r][c] + sx(arr_if.arr_a_bus[r*DATA_W +: DATA_W])
                                 * sx(arr_if.arr_b_bus[c*DATA_W +: DATA_W]);
      seen  <= 1'b1;
      drain <= 0;
    end else if (seen && drain < 1000) begin
      drain <= drain + 1;
    end
  end

  for (genvar gi = 0; gi < ROWS*COLS; gi++) begin : g_cbus
    assign arr_if.arr_c_bus[gi*ACC_W +: ACC_W] = acc[gi/COLS][gi%COLS];
  end
  assign arr_if.arr_c_valid = {(ROWS*COLS){seen && (drain >= DRAIN_CYC-1) && !kill}};

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          err;
    logic [CW-1:0] c;
    int            lat;
    int            beats;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  logic [CW-1:0] last_c = '0;
  int am [ROWS][K_MAX];
  int bm [K_MAX][COLS];

  int done_cnt = 0;
  int beats = 0;
  int clrs = 0;
  int start_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) begin
        start_cyc = cyc;
        beats = 0;
        clrs = 0;
      end
      if (arr_if.arr_valid_in) beats++;
      if (arr_if.arr_acc_clr) clrs++;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check_val("done_unexp", CW'(done), '0);
        end else begin
          e_mon = sb_q.pop_front();
          check_val("err", CW'(err), CW'(e_mon.err));
          check_val("latency", CW'(cyc - start_cyc), CW'(e_mon.lat));
          check_val("valid_beats", CW'(beats), CW'(e_mon.beats));
          check_val("clr_pulses", CW'(clrs), CW'(1));
          for (int i = 0; i < ROWS*COLS; i++)
            check_val($sformatf("c_out[%0d]", i), CW'(c_out[i*ACC_W +: ACC_W]),
                      CW'(e_mon.c[i*ACC_W +: ACC_W]));
          $display("run done: err=%0d lat=%0d beats=%0d c_out=%0h", err, cyc - start_cyc, beats, c_out);
        end
      end
    end
  end

  function automatic logic [CW-1:0] model_c(input int k);
    logic [CW-1:0] v = '0;
    int s;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += am[r][kk] * bm[kk][c];
        v[lane_lsb(c_lane(r, c, COLS), ACC_W) +: ACC_W] = ACC_W'(s);
      end
    return v;
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] pack_a(input int kk);
    logic [ROWS*DATA_W-1:0] v = '0;
    for (int r = 0; r < ROWS; r++) v[lane_lsb(r, DATA_W) +: DATA_W] = DATA_W'(am[r][kk]);
    return v;
  endfunction

  function automatic logic [COLS*DATA_W-1:0] pack_b(input int kk);
    logic [COLS*DATA_W-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[lane_lsb(c, DATA_W) +: DATA_W] = DATA_W'(bm[kk][c]);
    return v;
  endfunction

  task automatic set2x2(input int a00, a01, a10, a11, b00, b01, b10, b11);
    am[0][0] = a00; am[0][1] = a01; am[1][0] = a10; am[1][1] = a11;
    bm[0][0] = b00; bm[0][1] = b01; bm[1][0] = b10; bm[1][1] = b11;
  endtask

  // A and B written in the same cycle to exercise independent write ports.
  task automatic load_ops(input int k);
    for (int kk = 0; kk < k; kk++) begin
      @(posedge clk); #1;
      a_wr_en = 1'b1; a_wr_addr = AW'(kk); a_wr_data = pack_a(kk);
      b_wr_en = 1'b1; b_wr_addr = AW'(kk); b_wr_data = pack_b(kk);
    end
    @(posedge clk); #1;
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  task automatic push_exp(input int k, input bit e_err, input int lat);
    exp_t e;
    e.err   = e_err;
    e.lat   = lat;
    e.beats = (k == 0 || k > K_MAX) ? 0 : k;
    if (!e_err) last_c = model_c(k);
    e.c = last_c;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start(input int k, input bit wr0);
    @(posedge clk); #1;
    k_len = KW'(k);
    start = 1'b1;
    if (wr0) begin
      a_wr_en = 1'b1; a_wr_addr = '0; a_wr_data = pack_a(0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    a_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == prev) check_val("done_timeout", CW'(done_cnt), CW'(prev + 1));
    @(posedge clk); #1;
  endtask

  task automatic run(input int k, input bit e_err, input int lat, input bit wr0);
    int prev;
    push_exp(k, e_err, lat);
    prev = done_cnt;
    pulse_start(k, wr0);
    wait_done(prev, 200);
  endtask

  initial begin
    int prev;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", CW'(busy), '0);
    check_val("rst_done", CW'(done), '0);
    check_val("rst_err", CW'(err), '0);
    check_val("rst_acc_clr", CW'(arr_if.arr_acc_clr), '0);
    check_val("rst_valid_in", CW'(arr_if.arr_valid_in), '0);
    check_val("rst_a_bus", CW'(arr_if.arr_a_bus), '0);
    check_val("rst_b_bus", CW'(arr_if.arr_b_bus), '0);
    check_val("rst_c_out", c_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 2x2 tile
    set2x2(1, 2, 3, 4, 5, 6, 7, 8);
    load_ops(2);
    run(2, 1'b0, 2 + DRAIN_CYC + 2, 1'b0);

    // Busy protection: second start and an A write mid-STREAM
    push_exp(2, 1'b0, 2 + DRAIN_CYC + 2);
    prev = done_cnt;
    @(posedge clk); #1; k_len = KW'(2); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_wr_en = 1'b1; a_wr_addr = '0; a_wr_data = 16'h7f7f;
    @(posedge clk); #1; start = 1'b0; a_wr_en = 1'b0;
    wait_done(prev, 200);
    repeat (10) @(posedge clk);
    #1;
    check_val("one_done_pulse", CW'(done_cnt - prev), CW'(1));
    run(2, 1'b0, 2 + DRAIN_CYC + 2, 1'b0);

    // Bad k_len
    run(0, 1'b1, 2, 1'b0);
    run(K_MAX + 1, 1'b1, 2, 1'b0);

    // Drain timeout
    kill = 1'b1;
    run(2, 1'b1, 2 + FLUSH_MAX + 2, 1'b0);
    kill = 1'b0;

    // Reset during FLUSH
    prev = done_cnt;
    pulse_start(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_busy", CW'(busy), CW'(1));
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", CW'(busy), '0);
    check_val("midrst_valid_in", CW'(arr_if.arr_valid_in), '0);
    check_val("midrst_c_out", c_out, '0);
    last_c = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("midrst_no_done", CW'(done_cnt), CW'(prev));
    run(2, 1'b0, 2 + DRAIN_CYC + 2, 1'b0);

    // Signed operands
    set2x2(-1, 2, 3, -4, 5, -6, -7, 8);
    load_ops(2);
    run(2, 1'b0, 2 + DRAIN_CYC + 2, 1'b0);

    // A write landing with start is used by that run
    am[0][0] = 10;
    am[1][0] = -10;
    run(2, 1'b0, 2 + DRAIN_CYC + 2, 1'b1);

    // Shortest tile
    run(1, 1'b0, 1 + DRAIN_CYC + 2, 1'b0);

    // Full-depth tile with random operands
    for (int kk = 0; kk < K_MAX; kk++) begin
      for (int r = 0; r < ROWS; r++) am[r][kk] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) bm[kk][c] = int'($urandom_range(0, 255)) - 128;
    end
    load_ops(K_MAX);
    run(K_MAX, 1'b0, K_MAX + DRAIN_CYC + 2, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check_val("sb_empty", CW'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
